// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    function automatic logic [ADDR_W-3:0] word_index(input logic [ADDR_W-1:0] addr);
        return (ADDR_W-2)'(addr >> 2);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with byte-masked synchronous write and asynchronous read.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: one request at a time, fixed wait
// states, then a held response until the initiator takes it.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic [ADDR_W-3:0] cur_idx;
    logic              cur_err;
    logic              enter_resp;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rsp_rdata_d;

    // With no wait states, RESP is entered on the accepting edge itself,
    // so the request must be served straight from the input pins.
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
    end

    assign cur_idx = word_index(cur_addr);
    assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_idx >= DEPTH_L);

    always_comb begin
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE:    enter_resp = req_valid && (WAIT_STATES == 0);
            WAIT:    enter_resp = (cnt_q == 4'd0);
            default: enter_resp = 1'b0;
        endcase
    end

    assign mem_we      = enter_resp && cur_write && !cur_err;
    assign rsp_rdata_d = (!cur_write && !cur_err) ? mem_rdata : '0;

    data_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .be   (cur_be),
        .idx  (cur_idx[IW-1:0]),
        .wdata(cur_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                        cnt_q       <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
            // RESP entry overrides the plain IDLE/WAIT transitions above.
            if (enter_resp) begin
                state_q     <= RESP;
                req_ready_q <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= cur_err;
                rsp_rdata_q <= rsp_rdata_d;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
